// File: rtl/hazard_interlock_unit.sv
// Decode-stage hazard interlock: shadow pipeline of in-flight writers, per-source
// forwarding selects, stall/bubble generation and a consecutive-stall watchdog.
// Optional build macro: HAZARD_ZERO_REG_EN (register 0 reads as constant zero, never matches).
//
// watchdog state | meaning
// WD_ARMED       | counting consecutive stalls, timeout not yet seen
// WD_TRIPPED     | MAX_STALL consecutive stalls seen, timeout held until reset
module hazard_interlock_unit #(
  parameter int ADDR_W    = 4,
  parameter int NSRC      = 2,
  parameter int DEPTH     = 3,
  parameter int MAX_STALL = 15,
  parameter int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [NSRC*ADDR_W-1:0]             src_id,
  input  logic [NSRC-1:0]                    src_valid,
  input  logic                               is_branch,
  input  logic [ADDR_W-1:0]                  dest_id,
  input  logic                               wb_en,
  input  logic                               mem_r_en,
  input  logic                               forward_EN,
  input  logic                               flush,
  output logic                               stall,
  output logic [NSRC*SEL_W-1:0]              fwd_sel,
  output logic                               stall_timeout,
  output logic [$clog2(MAX_STALL+1)-1:0]     stall_cnt
);

  localparam int CW = $clog2(MAX_STALL + 1);

`ifdef HAZARD_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    WD_ARMED,
    WD_TRIPPED
  } wd_state_t;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  wb_q;
  logic [DEPTH-1:0]  mrd_q;
  logic [ADDR_W-1:0] dest_q [DEPTH];

  logic [NSRC-1:0]   hit;
  logic [NSRC-1:0]   load_use;
  logic [NSRC-1:0]   branch_near;
  logic [NSRC-1:0]   branch_load_mem;
  logic              hazard;
  logic              issue;

  wd_state_t         wd_state;
  wd_state_t         wd_state_nxt;
  logic [CW-1:0]     stall_cnt_nxt;

  // Per-source comparison against every tracked stage.
  for (genvar gk = 0; gk < NSRC; gk++) begin : g_src
    logic [ADDR_W-1:0] src;
    logic [DEPTH-1:0]  match;
    logic [SEL_W-1:0]  young;

    assign src = src_id[gk*ADDR_W +: ADDR_W];

    always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
        match[i] = valid_q[i] && wb_q[i] && src_valid[gk] && (dest_q[i] == src)
                   && !(ZERO_REG && ((src == '0) || (dest_q[i] == '0)));
      end
    end

    // Scan oldest to youngest so the lowest matching index is left standing.
    always_comb begin
      young = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (match[i]) young = SEL_W'(i);
      end
    end

    always_comb begin
      branch_near[gk]     = 1'b0;
      branch_load_mem[gk] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        // The branch compares in ID; EXE and MEM results cannot reach it in time.
        if (i < 2) branch_near[gk] = branch_near[gk] | (is_branch & match[i]);
        if (i == 1) branch_load_mem[gk] = is_branch && hit[gk] && (young == SEL_W'(i)) && mrd_q[i];
      end
    end

    assign hit[gk]      = |match;
    assign load_use[gk] = hit[gk] && (young == '0) && mrd_q[0];
    assign fwd_sel[gk*SEL_W +: SEL_W] = (forward_EN && hit[gk]) ? young + SEL_W'(1) : '0;
  end

  assign hazard = forward_EN ? |(load_use | branch_near | branch_load_mem) : |hit;
  assign stall  = id_valid && !flush && hazard;
  assign issue  = id_valid && !flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wb_q    <= '0;
      mrd_q   <= '0;
      for (int i = 0; i < DEPTH; i++) dest_q[i] <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        wb_q[i]    <= wb_q[i-1];
        mrd_q[i]   <= mrd_q[i-1];
        dest_q[i]  <= dest_q[i-1];
      end
      valid_q[0] <= issue;
      wb_q[0]    <= wb_en;
      mrd_q[0]   <= mem_r_en;
      dest_q[0]  <= dest_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_state  <= WD_ARMED;
      stall_cnt <= '0;
    end else begin
      wd_state  <= wd_state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    stall_cnt_nxt = '0;
    wd_state_nxt  = wd_state;
    if (stall) begin
      stall_cnt_nxt = (stall_cnt == CW'(MAX_STALL)) ? stall_cnt : stall_cnt + CW'(1);
    end
    case (wd_state)
      WD_ARMED: begin
        if (stall && (stall_cnt_nxt == CW'(MAX_STALL))) wd_state_nxt = WD_TRIPPED;
      end
      WD_TRIPPED: wd_state_nxt = WD_TRIPPED;
      default:    wd_state_nxt = WD_ARMED;
    endcase
  end

  assign stall_timeout = (wd_state == WD_TRIPPED);

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Scoreboard bench for hazard_interlock_unit: directed vectors push expectations,
// a negedge monitor pops and compares. A second instance (DEPTH=4, MAX_STALL=2) exercises the watchdog.
module tb_hazard_interlock_unit;

`ifdef HAZARD_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [7:0] src_id;
  logic [1:0] src_valid;
  logic       is_branch;
  logic [3:0] dest_id;
  logic       wb_en;
  logic       mem_r_en;
  logic       forward_EN;
  logic       flush;

  logic       stall;
  logic [3:0] fwd_sel;
  logic       stall_timeout;
  logic [3:0] stall_cnt;

  logic       wd_stall;
  logic [5:0] wd_fwd_sel;
  logic       wd_timeout;
  logic [1:0] wd_cnt;

  always #5 clk = ~clk;

  hazard_interlock_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_id(src_id), .src_valid(src_valid),
    .is_branch(is_branch), .dest_id(dest_id), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .forward_EN(forward_EN), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .stall_timeout(stall_timeout), .stall_cnt(stall_cnt)
  );

  hazard_interlock_unit #(.DEPTH(4), .MAX_STALL(2)) dut_wd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_id(src_id), .src_valid(src_valid),
    .is_branch(is_branch), .dest_id(dest_id), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .forward_EN(forward_EN), .flush(flush), .stall(wd_stall), .fwd_sel(wd_fwd_sel),
    .stall_timeout(wd_timeout), .stall_cnt(wd_cnt)
  );

  typedef struct {
    string      name;
    logic       stall;
    logic [3:0] fwd;
    logic       chk_fwd;
    logic [3:0] cnt;
    logic       tmo;
    logic       chk_wd;
    logic       wd_stall;
    logic [1:0] wd_cnt;
    logic       wd_tmo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic vec_valid = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] want);
    if (act !== want) begin
      n_err++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (vec_valid) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow got 0 entries expected 1");
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        chk(e.name, "stall", {7'd0, stall}, {7'd0, e.stall});
        if (e.chk_fwd) chk(e.name, "fwd_sel", {4'd0, fwd_sel}, {4'd0, e.fwd});
        chk(e.name, "stall_cnt", {4'd0, stall_cnt}, {4'd0, e.cnt});
        chk(e.name, "stall_timeout", {7'd0, stall_timeout}, {7'd0, e.tmo});
        if (e.chk_wd) begin
          chk(e.name, "wd_stall", {7'd0, wd_stall}, {7'd0, e.wd_stall});
          chk(e.name, "wd_cnt", {6'd0, wd_cnt}, {6'd0, e.wd_cnt});
          chk(e.name, "wd_timeout", {7'd0, wd_timeout}, {7'd0, e.wd_tmo});
        end
      end
    end
  end

  // One cycle of stimulus plus its expected response.
  task automatic vec(input string nm, input logic iv,
                     input logic [3:0] s0, input logic v0, input logic [3:0] s1, input logic v1,
                     input logic br, input logic [3:0] dst, input logic wb, input logic mrd,
                     input logic fl, input logic r,
                     input logic e_st, input logic [3:0] e_fwd, input logic [3:0] e_cnt, input logic e_tmo,
                     input logic c_fwd = 1'b1, input logic c_wd = 1'b0,
                     input logic e_wst = 1'b0, input logic [1:0] e_wcnt = 2'd0, input logic e_wtmo = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid  = iv;
    src_id    = {s1, s0};
    src_valid = {v1, v0};
    is_branch = br;
    dest_id   = dst;
    wb_en     = wb;
    mem_r_en  = mrd;
    flush     = fl;
    rst       = r;
    e.name = nm; e.stall = e_st; e.fwd = e_fwd; e.chk_fwd = c_fwd; e.cnt = e_cnt; e.tmo = e_tmo;
    e.chk_wd = c_wd; e.wd_stall = e_wst; e.wd_cnt = e_wcnt; e.wd_tmo = e_wtmo;
    sb.push_back(e);
    vec_valid = 1'b1;
  endtask

  task automatic do_reset(input logic fen);
    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    rst = 1'b1;
    id_valid = 1'b0; src_valid = '0; src_id = '0; is_branch = 1'b0;
    dest_id = '0; wb_en = 1'b0; mem_r_en = 1'b0; flush = 1'b0;
    forward_EN = fen;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; src_valid = '0; src_id = '0; is_branch = 1'b0;
    dest_id = '0; wb_en = 1'b0; mem_r_en = 1'b0; flush = 1'b0; forward_EN = 1'b0;

    // No forwarding: dependent SUB waits for ADD to leave all three stages.
    do_reset(1'b0);
    //   name       iv s0 v0 s1 v1 br dst wb mrd fl r  st fwd  cnt tmo
    vec("t1_add",   1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t1_sub_a", 1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4'h0, 0, 0);
    vec("t1_sub_b", 1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4'h0, 1, 0);
    vec("t1_sub_c", 1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4'h0, 2, 0);
    vec("t1_sub_go",1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h0, 3, 0);
    vec("t1_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Forwarding distance 1, 2, 3 and both sources on the same producer.
    do_reset(1'b1);
    vec("t2_add5",  1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_fwd1",  1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'h4, 0, 0);
    vec("t2_add6",  1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_gap1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_fwd2",  1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 4'h8, 0, 0);
    vec("t2_add8",  1, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_gap2a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_gap2b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_fwd3",  1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'hC, 0, 0);
    vec("t2_add9",  1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t2_both",  1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0);

    // Load-use: one stall, then forward from MEM.
    do_reset(1'b1);
    vec("t3_load",  1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 4'h0, 0, 0);
    vec("t3_use_st",1, 7, 1, 0, 0, 0,10, 1, 0, 0, 0, 1, 4'h1, 0, 0);
    vec("t3_use_go",1, 7, 1, 0, 0, 0,10, 1, 0, 0, 0, 0, 4'h2, 1, 0);
    vec("t3_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);

    // id_valid=0 never stalls and lets a bubble in.
    do_reset(1'b1);
    vec("t3b_load", 1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 4'h0, 0, 0);
    vec("t3b_novld",0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1'b0);
    vec("t3b_use",  1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);

    // Branch interlock, then flush beating a hazard and leaving a bubble.
    do_reset(1'b1);
    vec("t4_add2",  1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t4_beq_a", 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h1, 0, 0);
    vec("t4_beq_b", 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h2, 1, 0);
    vec("t4_beq_go",1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h3, 2, 0);
    vec("t4_add11", 1, 0, 0, 0, 0, 0,11, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t4_flush", 1,11, 1, 0, 0, 1,12, 1, 0, 1, 0, 0, 4'h1, 0, 0);
    vec("t4_bubble",1,12, 1,11, 1, 0, 0, 0, 0, 0, 0, 0, 4'h8, 0, 0);

    // Watchdog on the MAX_STALL=2 instance, then async reset mid-stall.
    do_reset(1'b0);
    //   name       iv s0 v0 s1 v1 br dst wb mrd fl r  st fwd  cnt tmo cf cw wst wcnt wtmo
    vec("t5_add3",  1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 0);
    vec("t5_st1",   1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4'h0, 0, 0, 1, 1, 1, 0, 0);
    vec("t5_st2",   1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4'h0, 1, 0, 1, 1, 1, 1, 0);
    vec("t5_st3",   1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4'h0, 2, 0, 1, 1, 1, 2, 1);
    vec("t5_rst",   1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 1, 0, 4'h0, 0, 0, 1, 1, 0, 0, 0);
    vec("t5_post",  1, 3, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 0);

    // Register 0 as a producer: zero-register build ignores it.
    do_reset(1'b1);
    vec("t6_add0f", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t6_fwd0",  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZR ? 4'h0 : 4'h1, 0, 0);
    do_reset(1'b0);
    vec("t6_add0s", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    vec("t6_stall0",1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, ZR ? 1'b0 : 1'b1, 4'h0, 0, 0);

    do_reset(1'b0);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
